// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter_sched sequencing controller.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int COUNT_W        = 16;
    localparam int PRESCALE_W_DEF = 8;

endpackage

// File: rtl/counter_sched_core.sv
// Counter datapath: WIDTH-bit register with clear/enable and a terminal compare.
module counter_sched_core
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so a terminal tick lands on 0 instead of limit+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/counter_sched.sv
// Start/pause/resume/abort sequencer for a shared up-counter with one-shot and periodic modes.
// Optional tick prescaler enabled by defining COUNTER_SCHED_PRESCALE_EN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = COUNT_W
`ifdef COUNTER_SCHED_PRESCALE_EN
    , parameter int PRESCALE_W = PRESCALE_W_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic                  cfg_periodic,
`ifdef COUNTER_SCHED_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] cfg_prescale,
`endif
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  done_pulse
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_limit;
    logic             r_periodic;
    logic             r_done;
    logic             w_clr;
    logic             w_en;
    logic             w_done_set;
    logic             w_tick;
    logic             w_at_limit;
    logic             w_cfg_fire;

    assign cfg_ready  = (r_state == IDLE) || (r_state == DONE);
    assign busy       = (r_state == RUN) || (r_state == HOLD);
    assign done_pulse = r_done;
    assign w_cfg_fire = cfg_valid && cfg_ready;

`ifdef COUNTER_SCHED_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pre;

    assign w_tick = (r_pre == r_prescale);

    // Phase is zeroed outside RUN/HOLD so every fresh run starts aligned; HOLD keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_pre      <= '0;
        end else begin
            if (w_cfg_fire) begin
                r_prescale <= cfg_prescale;
            end
            if ((r_state == IDLE) || (r_state == DONE)) begin
                r_pre <= '0;
            end else if ((r_state == RUN) && !stop) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            end
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // stop is tested first in every state so a simultaneous start/stop always resolves to stop.
    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_en       = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop && (r_limit != '0)) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next = HOLD;
                end else if (w_tick) begin
                    if (w_at_limit) begin
                        w_clr      = 1'b1;
                        w_done_set = 1'b1;
                        w_next     = r_periodic ? RUN : DONE;
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                end else if (start) begin
                    w_next = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    w_next = IDLE;
                end else if (start) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
                w_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_limit    <= '1;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            if (w_cfg_fire) begin
                r_limit    <= cfg_limit;
                r_periodic <= cfg_periodic;
            end
        end
    end

    counter_sched_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_en      (w_en),
        .i_limit   (r_limit),
        .o_count   (count),
        .o_at_limit(w_at_limit)
    );

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: each scenario queues per-cycle stimulus with its expected outputs.
module tb_counter_sched;

    typedef struct packed {
        logic rst;
        logic start;
        logic stop;
        logic cfgValid;
    } stim_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        done;
        logic [15:0] count;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  o;
    } plan_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_limit = 16'd0;
    logic        cfg_periodic = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic [15:0] count;
    logic        done_pulse;
`ifdef COUNTER_SCHED_PRESCALE_EN
    logic [7:0]  cfg_prescale = 8'd0;
`endif

    int    checks = 0;
    int    failures = 0;
    plan_t planQ[$];
    obs_t  sbQ[$];

    counter_sched dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_limit   (cfg_limit),
        .cfg_periodic(cfg_periodic),
`ifdef COUNTER_SCHED_PRESCALE_EN
        .cfg_prescale(cfg_prescale),
`endif
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .count       (count),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(bit r, bit go, bit halt, bit cv);
        st = '{rst: r, start: go, stop: halt, cfgValid: cv};
    endfunction

    function automatic obs_t mk(bit b, bit rdy, bit d, int c);
        mk = '{busy: b, ready: rdy, done: d, count: 16'(c)};
    endfunction

    function automatic obs_t observed();
        observed = '{busy: busy, ready: cfg_ready, done: done_pulse, count: count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input stim_t s, input obs_t o);
        planQ.push_back('{s: s, o: o});
    endtask

    task automatic drive(input stim_t s);
        rst       = s.rst;
        start     = s.start;
        stop      = s.stop;
        cfg_valid = s.cfgValid;
    endtask

    task automatic configure(input logic [15:0] lim, input logic per);
        cfg_limit    = lim;
        cfg_periodic = per;
        drive(st(0, 0, 0, 1));
        step();
        drive(st(0, 0, 0, 0));
    endtask

    task automatic test_reset();
        obs_t exp, got;
        drive(st(1, 0, 0, 0));
        sbQ.push_back(mk(0, 1, 0, 0));
        step();
        step();
        exp = sbQ.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL reset: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                     got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
        end
        drive(st(0, 0, 0, 0));
        sbQ.push_back(mk(0, 1, 0, 0));
        step();
        exp = sbQ.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL reset_release: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                     got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
        end
    endtask

    task automatic test_oneshot();
        plan_t p;
        obs_t  exp, got;
        configure(16'd3, 1'b0);
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 2));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 3));
        add(st(0, 0, 0, 0), mk(0, 1, 1, 0));
        add(st(0, 0, 0, 0), mk(0, 1, 0, 0));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL oneshot cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

    task automatic test_periodic();
        plan_t p;
        obs_t  exp, got;
        configure(16'd2, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            add(st(0, c == 1, 0, 0), mk(1, 0, (c == 4) || (c == 7), (c - 1) % 3));
        end
        add(st(0, 0, 1, 0), mk(1, 0, 0, 2));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL periodic cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

    task automatic test_hold_resume();
        plan_t p;
        obs_t  exp, got;
        configure(16'd5, 1'b0);
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 2));
        add(st(0, 0, 1, 0), mk(1, 0, 0, 2));
        for (int k = 0; k < 3; k++) add(st(0, 0, 0, 0), mk(1, 0, 0, 2));
        add(st(0, 1, 0, 0), mk(1, 0, 0, 2));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 3));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 4));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 5));
        add(st(0, 0, 0, 0), mk(0, 1, 1, 0));
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 1, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL hold_resume cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

    task automatic test_start_stop_cfg_stall();
        plan_t p;
        obs_t  exp, got;
        configure(16'd5, 1'b0);
        cfg_limit    = 16'd2;
        cfg_periodic = 1'b1;
        add(st(0, 1, 1, 0), mk(0, 1, 0, 0));
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 1, 1, 0), mk(1, 0, 0, 1));
        add(st(0, 1, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 1), mk(1, 0, 0, 2));
        add(st(0, 0, 0, 1), mk(1, 0, 0, 3));
        add(st(0, 0, 0, 1), mk(1, 0, 0, 4));
        add(st(0, 0, 0, 1), mk(1, 0, 0, 5));
        add(st(0, 0, 0, 0), mk(0, 1, 1, 0));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL start_stop_cfg cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

    task automatic test_limit_zero();
        plan_t p;
        obs_t  exp, got;
        configure(16'd0, 1'b0);
        add(st(0, 1, 0, 0), mk(0, 1, 0, 0));
        add(st(0, 1, 0, 0), mk(0, 1, 0, 0));
        add(st(0, 0, 0, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL limit_zero cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        plan_t p;
        obs_t  exp, got;
        configure(16'd10, 1'b0);
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        for (int k = 1; k <= 7; k++) add(st(0, 0, 0, 0), mk(1, 0, 0, k));
        add(st(1, 0, 0, 0), mk(0, 1, 0, 0));
        add(st(0, 0, 0, 0), mk(0, 1, 0, 0));
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 1, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL reset_mid_run cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
    endtask

`ifdef COUNTER_SCHED_PRESCALE_EN
    task automatic test_prescale();
        plan_t p;
        obs_t  exp, got;
        cfg_prescale = 8'd2;
        configure(16'd1, 1'b0);
        cfg_prescale = 8'd0;
        add(st(0, 1, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 0));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 0), mk(1, 0, 0, 1));
        add(st(0, 0, 0, 0), mk(0, 1, 1, 0));
        add(st(0, 0, 1, 0), mk(0, 1, 0, 0));
        for (int i = 1; planQ.size() > 0; i++) begin
            p = planQ.pop_front();
            drive(p.s);
            sbQ.push_back(p.o);
            step();
            exp = sbQ.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL prescale cycle %0d: got busy=%0b ready=%0b done=%0b count=%0d, expected busy=%0b ready=%0b done=%0b count=%0d",
                         i, got.busy, got.ready, got.done, got.count, exp.busy, exp.ready, exp.done, exp.count);
            end
        end
        configure(16'd1, 1'b0);
    endtask
`endif

    initial begin
        $display("[TB] counter_sched bench starting");
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold_resume();
        test_start_stop_cfg_stall();
        test_limit_zero();
        test_reset_mid_run();
`ifdef COUNTER_SCHED_PRESCALE_EN
        test_prescale();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
